// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the parametrised UART receiver family:
//   parity mode codes, the receive state encoding and the baud counter
//   width helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4,
    BRK   = 3'd5
  } rx_state_e;

  // Width of a counter that spans 0..(clk_freq/baud)-1.
  function automatic int baud_cnt_w(input int clk_freq, input int baud);
    int n;
    n = clk_freq / baud;
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if
//   Received-frame bus of the UART receiver.
//   rx_data    : last received word, LSB first on the line
//   rx_vld     : one-cycle frame-complete pulse
//   parity_err : parity mismatch, meaningful only with rx_vld
//   frame_err  : stop bit sampled low, meaningful only with rx_vld
//   busy       : receiver is inside a frame (or waiting out a break)
//   master = receiver side, slave = byte consumer side.
interface uart_rx_param_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] rx_data;
  logic              rx_vld;
  logic              parity_err;
  logic              frame_err;
  logic              busy;

  modport master (
    output rx_data,
    output rx_vld,
    output parity_err,
    output frame_err,
    output busy
  );

  modport slave (
    input rx_data,
    input rx_vld,
    input parity_err,
    input frame_err,
    input busy
  );

endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync
//   Three-flop synchroniser for an asynchronous, idle-high serial line
//   plus falling-edge detection on the synchronised value.
//   clk          : system clock
//   rst_n        : asynchronous active-low reset (flops reset to idle 1)
//   i_rx         : raw serial line
//   o_rx_s       : synchronised line (second flop)
//   o_start_edge : synchronised line has just fallen (1 -> 0)
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_rx,
  output logic o_rx_s,
  output logic o_start_edge
);

  logic r_ff0;
  logic r_ff1;
  logic r_ff2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ff0 <= 1'b1;
      r_ff1 <= 1'b1;
      r_ff2 <= 1'b1;
    end else begin
      r_ff0 <= i_rx;
      r_ff1 <= r_ff0;
      r_ff2 <= r_ff1;
    end
  end

  assign o_rx_s       = r_ff1;
  assign o_start_edge = ~r_ff1 & r_ff2;

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param
//   Parametrised UART receiver: DATA_W data bits, optional odd/even
//   parity, one stop bit, baud divisor CLK_FREQ/BAUD (rounded down).
//   Every bit is sampled once, at the middle of its bit period.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   rx_uart : serial line, idle high
//   rx_if   : received-frame bus (rx_data, rx_vld, parity_err,
//             frame_err, busy)
//
//   state | meaning
//   IDLE  | line idle, waiting for a falling edge
//   START | inside start bit; a high mid-bit sample is a glitch
//   DATA  | shifting in DATA_W data bits, LSB first
//   PAR   | sampling the parity bit
//   STOP  | sampling the stop bit; the frame is reported here
//   BRK   | stop bit was low; waiting for the line to return high
module uart_rx_param #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 9600,
  parameter int DATA_W   = 8,
  parameter int PARITY   = 0,
  parameter int STOP_CHK = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx_uart,
  uart_rx_param_if.master    rx_if
);

  import uart_pkg::*;

  localparam int BAUD_CNT = CLK_FREQ / BAUD;
  localparam int CNT_W    = baud_cnt_w(CLK_FREQ, BAUD);
  localparam int BIT_W    = $clog2(DATA_W + 1);

  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BAUD_CNT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_CNT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  rx_state_e         r_state;
  rx_state_e         w_state_nxt;
  logic [CNT_W-1:0]  r_baud_cnt;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_par_bit;
  logic [DATA_W-1:0] r_data;
  logic              r_vld;
  logic              r_parity_err;
  logic              r_frame_err;

  logic w_rx_s;
  logic w_start_edge;
  logic w_mid;
  logic w_end;
  logic w_par_x;
  logic w_par_bad;
  logic w_report;

  uart_rx_sync u_sync (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_rx         (rx_uart),
    .o_rx_s       (w_rx_s),
    .o_start_edge (w_start_edge)
  );

  assign w_mid    = (r_baud_cnt == CNT_MID);
  assign w_end    = (r_baud_cnt == CNT_LAST);
  assign w_report = (r_state == STOP) && w_mid;

  // XOR over data and parity bit: odd parity expects 1, even expects 0.
  assign w_par_x = (^r_shift) ^ r_par_bit;

  always_comb begin
    w_par_bad = 1'b0;
    if (PARITY == PAR_ODD) begin
      w_par_bad = ~w_par_x;
    end else if (PARITY == PAR_EVEN) begin
      w_par_bad = w_par_x;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_start_edge) w_state_nxt = START;
      end
      START: begin
        if (w_mid && w_rx_s) begin
          w_state_nxt = IDLE;
        end else if (w_end) begin
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_end && (r_bit_cnt == BIT_LAST)) begin
          w_state_nxt = (PARITY != PAR_NONE) ? PAR : STOP;
        end
      end
      PAR: begin
        if (w_end) w_state_nxt = STOP;
      end
      STOP: begin
        // Leaving at mid-bit rather than end of bit tolerates up to half a
        // bit of drift between back-to-back frames.
        if (w_mid) begin
          w_state_nxt = (w_rx_s || (STOP_CHK == 0)) ? IDLE : BRK;
        end
      end
      BRK: begin
        if (w_rx_s) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Both counters restart on every state change so each state sees its
  // own bit timing from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (w_state_nxt != r_state) begin
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (r_state != IDLE) begin
      if (w_end) begin
        r_baud_cnt <= '0;
        r_bit_cnt  <= r_bit_cnt + 1'b1;
      end else begin
        r_baud_cnt <= r_baud_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_par_bit <= 1'b0;
    end else begin
      if ((r_state == DATA) && w_mid) begin
        for (int i = 0; i < DATA_W; i++) begin
          if (r_bit_cnt == BIT_W'(i)) r_shift[i] <= w_rx_s;
        end
      end
      if ((r_state == PAR) && w_mid) begin
        r_par_bit <= w_rx_s;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data       <= '0;
      r_vld        <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_vld        <= w_report;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_report) begin
        r_data       <= r_shift;
        r_parity_err <= w_par_bad;
        r_frame_err  <= (STOP_CHK != 0) && !w_rx_s;
      end
    end
  end

  assign rx_if.rx_data    = r_data;
  assign rx_if.rx_vld     = r_vld;
  assign rx_if.parity_err = r_parity_err;
  assign rx_if.frame_err  = r_frame_err;
  assign rx_if.busy       = (r_state != IDLE);

endmodule
